// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, one bit per clock LSB first, fed by the ones-complement stage.
// Result and ALU flags are published together on the cycle the FSM enters DONE.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Bc,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] s_sh_r;
  logic             carry_r;
  logic [CW-1:0]    count_r;
  logic             bit_s;
  logic             carry_nxt_s;
  logic [WIDTH-1:0] s_nxt_s;
  logic             last_s;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from state
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state_r)
      IDLE:    ready = 1'b1;
      DONE:    done  = 1'b1;
      default: begin
        ready = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // One full-adder slice; the new sum bit enters s_sh from the top so the LSB lands at bit 0
  always_comb begin
    bit_s       = a_sh_r[0] ^ b_sh_r[0] ^ carry_r;
    carry_nxt_s = maj3(a_sh_r[0], b_sh_r[0], carry_r);
    s_nxt_s     = {bit_s, s_sh_r[WIDTH-1:1]};
    last_s      = (count_r == CW'(WIDTH - 1));
  end

  // Operand/sum shifters and published result; carry_r still holds the carry into the MSB on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      s_sh_r  <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      count_r <= {CW{1'b0}};
      Result  <= {WIDTH{1'b0}};
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r  <= A;
            b_sh_r  <= Bc;
            carry_r <= cin;
            count_r <= {CW{1'b0}};
            s_sh_r  <= {WIDTH{1'b0}};
          end
        end
        RUN: begin
          a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
          carry_r <= carry_nxt_s;
          s_sh_r  <= s_nxt_s;
          count_r <= count_r + CW'(1);
          if (last_s) begin
            Result <= s_nxt_s;
            cout   <= carry_nxt_s;
            ovf    <= carry_r ^ carry_nxt_s;
            zero   <= (s_nxt_s == {WIDTH{1'b0}});
            neg    <= bit_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: directed 4-bit and 8-bit vectors, expectations queued
// at issue time and checked by per-instance monitors on each done pulse.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] res;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic       neg;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = 4'd0, b4 = 4'd0;
  logic       ready4, done4, cout4, ovf4, zero4, neg4;
  logic [3:0] res4;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = 8'd0, b8 = 8'd0;
  logic       ready8, done8, cout8, ovf8, zero8, neg8;
  logic [7:0] res8;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q4[$];
  exp_t q8[$];

  serial_addsub #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .Bc(b4), .cin(cin4),
    .ready(ready4), .done(done4), .Result(res4), .cout(cout4), .ovf(ovf4),
    .zero(zero4), .neg(neg4)
  );

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .Bc(b8), .cin(cin8),
    .ready(ready8), .done(done8), .Result(res8), .cout(cout8), .ovf(ovf8),
    .zero(zero8), .neg(neg8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) begin
        chk("w4_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("w4_result", {28'd0, res4}, {24'd0, e.res});
        chk("w4_cout", {31'd0, cout4}, {31'd0, e.cout});
        chk("w4_ovf", {31'd0, ovf4}, {31'd0, e.ovf});
        chk("w4_zero", {31'd0, zero4}, {31'd0, e.zero});
        chk("w4_neg", {31'd0, neg4}, {31'd0, e.neg});
        chk("w4_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("w8_result", {24'd0, res8}, {24'd0, e.res});
        chk("w8_cout", {31'd0, cout8}, {31'd0, e.cout});
        chk("w8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
        chk("w8_zero", {31'd0, zero8}, {31'd0, e.zero});
        chk("w8_neg", {31'd0, neg8}, {31'd0, e.neg});
        chk("w8_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one 4-bit op; returns at the negedge after the accepting edge with start dropped
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [3:0] r, input logic co, input logic ov,
                        input logic z, input logic n, input bit push);
    int k = 0;
    exp_t e;
    @(negedge clk);
    while (ready4 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("w4_ready_timeout", 32'd0, 32'd1);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    e.res = {4'd0, r}; e.cout = co; e.ovf = ov; e.zero = z; e.neg = n;
    e.cyc = cyc + 1 + 4;
    if (push) q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [7:0] r, input logic co, input logic ov,
                        input logic z, input logic n);
    int k = 0;
    exp_t e;
    @(negedge clk);
    while (ready8 !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("w8_ready_timeout", 32'd0, 32'd1);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    e.res = r; e.cout = co; e.ovf = ov; e.zero = z; e.neg = n;
    e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((q4.size() != 0 || q8.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("queues_drained", q4.size() + q8.size(), 32'd0);
  endtask

  initial begin
    int a1;
    // Reset state
    #12;
    chk("rst_ready", {31'd0, ready4}, 32'd1);
    chk("rst_done", {31'd0, done4}, 32'd0);
    chk("rst_result", {28'd0, res4}, 32'd0);
    chk("rst_flags", {28'd0, cout4, ovf4, zero4, neg4}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Add 0101+0011 with ready profile
    issue4(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("ready_low_in_op", {31'd0, ready4}, 32'd0);
      @(negedge clk);
    end
    chk("ready_low_in_done", {31'd0, ready4}, 32'd0);
    @(negedge clk);
    chk("ready_back", {31'd0, ready4}, 32'd1);

    // Subtract and overflow vectors
    issue4(4'b0101, 4'b1100, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    issue4(4'b0111, 4'b1000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    issue4(4'b0011, 4'b1010, 1'b1, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    issue4(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    issue4(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    // Busy protection and back-to-back with start held
    @(negedge clk);
    a4 = 4'b0101; b4 = 4'b0011; cin4 = 1'b0; start4 = 1'b1;
    a1 = cyc + 1;
    q4.push_back('{res: 8'h08, cout: 1'b0, ovf: 1'b1, zero: 1'b0, neg: 1'b1, cyc: a1 + 4});
    @(negedge clk);
    a4 = 4'b0010; b4 = 4'b0001; cin4 = 1'b0;
    q4.push_back('{res: 8'h03, cout: 1'b0, ovf: 1'b0, zero: 1'b0, neg: 1'b0, cyc: a1 + 10});
    repeat (6) @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    chk("result_held", {28'd0, res4}, 32'h8);
    drain();

    // Reset mid-run
    issue4(4'b0110, 4'b0101, 1'b0, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", {28'd0, res4}, 32'd0);
    chk("midrst_flags", {28'd0, cout4, ovf4, zero4, neg4}, 32'd0);
    chk("midrst_ready", {31'd0, ready4}, 32'd1);
    chk("midrst_done", {31'd0, done4}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue4(4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    // 8-bit vectors
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    issue8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    issue8(8'h80, 8'hFE, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    issue8(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, 1'b1);
    issue8(8'h12, 8'hCB, 1'b1, 8'hDE, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
